// File: rtl/exec_mem_unit_pkg.sv
// ============================================================================
// exec_mem_unit_pkg : shared ALU opcodes, access-size encodings and data width
// Revision: 1.0
// ============================================================================
`default_nettype none

package exec_mem_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_PASA = 4'b1011;
  localparam logic [3:0] ALU_PASB = 4'b1100;
  localparam logic [3:0] ALU_PC8  = 4'b1101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

`default_nettype wire

// File: rtl/exec_mem_unit_byte_ram.sv
// ============================================================================
// exec_mem_unit_byte_ram : big-endian byte RAM, sync write, comb read/extend
// Revision: 1.0
// ============================================================================
`default_nettype none

module exec_mem_unit_byte_ram
  import exec_mem_unit_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  input  logic [1:0]        size,
  input  logic              rw,
  input  logic              en,
  input  logic              se,
  output logic [DATA_W-1:0] do_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Natural ADDR_W-bit overflow gives the wrap-around past the top byte.
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  assign a0 = addr;
  assign a1 = addr + ADDR_W'(1);
  assign a2 = addr + ADDR_W'(2);
  assign a3 = addr + ADDR_W'(3);

  always_comb begin
    mem_d = mem_q;
    if (en && rw) begin
      case (size)
        SZ_BYTE: mem_d[a0] = di[7:0];
        SZ_HALF: begin
          mem_d[a0] = di[15:8];
          mem_d[a1] = di[7:0];
        end
        default: begin
          mem_d[a0] = di[31:24];
          mem_d[a1] = di[23:16];
          mem_d[a2] = di[15:8];
          mem_d[a3] = di[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      mem_q <= mem_d;
    end
  end

  logic [7:0] b0, b1, b2, b3;
  logic       fill;
  assign b0 = mem_q[a0];
  assign b1 = mem_q[a1];
  assign b2 = mem_q[a2];
  assign b3 = mem_q[a3];
  assign fill = se & b0[7];

  always_comb begin
    do_o = '0;
    if (en && !rw) begin
      case (size)
        SZ_BYTE: do_o = {{(DATA_W-8){fill}}, b0};
        SZ_HALF: do_o = {{(DATA_W-16){fill}}, b0, b1};
        default: do_o = {b0, b1, b2, b3};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/exec_mem_unit.sv
// ============================================================================
// exec_mem_unit : PC+4 incrementer, 32-bit ALU with Z/N flags, 512-byte RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module exec_mem_unit #(
  parameter int MEM_ADDR_W = 9,
  parameter int DATA_W     = exec_mem_unit_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     pc_in,
  output logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     alu_a,
  input  logic [DATA_W-1:0]     alu_b,
  input  logic [3:0]            alu_op,
  output logic [DATA_W-1:0]     alu_out,
  output logic                  alu_z,
  output logic                  alu_n,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_di,
  input  logic [1:0]            mem_size,
  input  logic                  mem_rw,
  input  logic                  mem_en,
  input  logic                  mem_se,
  output logic [DATA_W-1:0]     mem_do
);

  import exec_mem_unit_pkg::*;

  assign pc_plus4 = pc_in + DATA_W'(4);

  logic [4:0] shamt;
  assign shamt = alu_a[4:0];

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_NOR:  alu_out = ~(alu_a | alu_b);
      ALU_SLL:  alu_out = alu_b << shamt;
      ALU_SRL:  alu_out = alu_b >> shamt;
      ALU_SRA:  alu_out = $signed(alu_b) >>> shamt;
      ALU_SLT:  alu_out = {{(DATA_W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {{(DATA_W-1){1'b0}}, alu_a < alu_b};
      ALU_PASA: alu_out = alu_a;
      ALU_PASB: alu_out = alu_b;
      ALU_PC8:  alu_out = alu_b + DATA_W'(8);
      default:  alu_out = '0;
    endcase
  end

  assign alu_z = (alu_out == '0);
  assign alu_n = alu_out[DATA_W-1];

  exec_mem_unit_byte_ram #(
    .ADDR_W (MEM_ADDR_W)
  ) u_byte_ram (
    .clk   (clk),
    .reset (reset),
    .addr  (mem_addr),
    .di    (mem_di),
    .size  (mem_size),
    .rw    (mem_rw),
    .en    (mem_en),
    .se    (mem_se),
    .do_o  (mem_do)
  );

endmodule

`default_nettype wire

// File: tb/tb_exec_mem_unit.sv
// ============================================================================
// tb_exec_mem_unit : directed self-checking bench for exec_mem_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, pc_plus4;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_z, alu_n;
  logic [8:0]  mem_addr;
  logic [31:0] mem_di, mem_do;
  logic [1:0]  mem_size;
  logic        mem_rw, mem_en, mem_se;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  exec_mem_unit dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc_in),
    .pc_plus4 (pc_plus4),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_z    (alu_z),
    .alu_n    (alu_n),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_size (mem_size),
    .mem_rw   (mem_rw),
    .mem_en   (mem_en),
    .mem_se   (mem_se),
    .mem_do   (mem_do)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; alu_a = a; alu_b = b;
    #1;
  endtask

  task automatic mem_write(input logic [8:0] addr, input logic [1:0] sz, input logic [31:0] di);
    @(negedge clk);
    mem_addr = addr; mem_size = sz; mem_di = di; mem_en = 1'b1; mem_rw = 1'b1;
    @(posedge clk);
    #1;
    mem_en = 1'b0; mem_rw = 1'b0;
  endtask

  task automatic mem_read(input string tag, input logic [8:0] addr, input logic [1:0] sz,
                          input logic se, input logic [31:0] exp);
    mem_addr = addr; mem_size = sz; mem_se = se; mem_en = 1'b1; mem_rw = 1'b0;
    #1;
    check(tag, mem_do, exp);
    mem_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pc_in = '0; alu_a = '0; alu_b = '0; alu_op = '0;
    mem_addr = '0; mem_di = '0; mem_size = 2'b10; mem_rw = 1'b0; mem_en = 1'b0; mem_se = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_read("reset_word0", 9'd0, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Incrementer
    pc_in = 32'h0000_0000; #1; check("pc4_zero", pc_plus4, 32'h0000_0004);
    pc_in = 32'hFFFF_FFFC; #1; check("pc4_wrap", pc_plus4, 32'h0000_0000);

    // ALU arithmetic and flags
    alu(4'b0001, 32'd5, 32'd5);
    check("sub_out", alu_out, 32'h0); check("sub_z", {31'b0, alu_z}, 32'd1);
    check("sub_n", {31'b0, alu_n}, 32'd0);
    alu(4'b0000, 32'h7FFF_FFFF, 32'd1);
    check("add_out", alu_out, 32'h8000_0000); check("add_n", {31'b0, alu_n}, 32'd1);
    check("add_z", {31'b0, alu_z}, 32'd0);
    alu(4'b1101, 32'h1234_5678, 32'h10); check("pc8", alu_out, 32'h18);
    alu(4'b0101, 32'h0, 32'h0);         check("nor", alu_out, 32'hFFFF_FFFF);
    alu(4'b0100, 32'hF0F0_1234, 32'h0FF0_1230); check("xor", alu_out, 32'hFF00_0004);
    alu(4'b0110, 32'd36, 32'd1);        check("sll_mask", alu_out, 32'h10);
    alu(4'b0111, 32'd4, 32'h8000_0000); check("srl", alu_out, 32'h0800_0000);

    // ALU shifts and compares
    alu(4'b1000, 32'd4, 32'h8000_0000); check("sra", alu_out, 32'hF800_0000);
    alu(4'b1001, 32'hFFFF_FFFF, 32'd1); check("slt", alu_out, 32'd1);
    alu(4'b1010, 32'hFFFF_FFFF, 32'd1); check("sltu", alu_out, 32'd0);
    alu(4'b1011, 32'hCAFE_0001, 32'd7); check("pass_a", alu_out, 32'hCAFE_0001);
    alu(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("op14_out", alu_out, 32'h0); check("op14_z", {31'b0, alu_z}, 32'd1);

    // Memory word write then reads
    mem_write(9'd4, 2'b10, 32'hA1B2_C3D4);
    mem_read("rd_b4_se",  9'd4, 2'b00, 1'b1, 32'hFFFF_FFA1);
    mem_read("rd_b4_ze",  9'd4, 2'b00, 1'b0, 32'h0000_00A1);
    mem_read("rd_h6_ze",  9'd6, 2'b01, 1'b0, 32'h0000_C3D4);
    mem_read("rd_h6_se",  9'd6, 2'b01, 1'b1, 32'hFFFF_C3D4);
    mem_read("rd_w4",     9'd4, 2'b10, 1'b1, 32'hA1B2_C3D4);
    mem_read("rd_w4_sz3", 9'd4, 2'b11, 1'b0, 32'hA1B2_C3D4);
    mem_read("rd_h5_una", 9'd5, 2'b01, 1'b0, 32'h0000_B2C3);

    // Halfword wrap, byte write, idle outputs
    mem_write(9'd511, 2'b01, 32'hFFFF_1234);
    mem_read("rd_b511", 9'd511, 2'b00, 1'b0, 32'h12);
    mem_read("rd_b0",   9'd0,   2'b00, 1'b0, 32'h34);
    mem_read("rd_w510", 9'd510, 2'b10, 1'b0, 32'h0012_3400);
    mem_write(9'd9, 2'b00, 32'hFFFF_FF5A);
    mem_read("rd_w8", 9'd8, 2'b10, 1'b0, 32'h005A_0000);
    mem_addr = 9'd4; mem_size = 2'b10; mem_en = 1'b0; mem_rw = 1'b0; #1;
    check("idle_en0", mem_do, 32'h0);
    mem_en = 1'b1; mem_rw = 1'b1; mem_di = 32'h0; mem_addr = 9'd100; #1;
    check("idle_rw1", mem_do, 32'h0);
    mem_en = 1'b0; mem_rw = 1'b0;

    // Asynchronous reset mid-cycle, write during reset dropped
    @(posedge clk);
    #3;
    mem_addr = 9'd4; mem_size = 2'b10; mem_en = 1'b1; mem_rw = 1'b0; #1;
    check("pre_reset_w4", mem_do, 32'hA1B2_C3D4);
    reset = 1'b1; #1;
    check("async_reset_w4", mem_do, 32'h0);
    pc_in = 32'h0000_1000; #1;
    check("pc4_in_reset", pc_plus4, 32'h0000_1004);
    mem_write(9'd12, 2'b10, 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b0;
    mem_read("drop_w12", 9'd12, 2'b10, 1'b0, 32'h0);
    mem_read("post_w510", 9'd510, 2'b10, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
